// File: rtl/carregador_pkg.sv
// Shared types, default sizes and the block-length rule for the HD program loader.
package carregador_pkg;
    localparam int BLOCK_SIZE_DEF = 200;
    localparam int NUM_BLOCKS_DEF = 8;
    localparam int LEN_W          = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHECK  = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_FINISH = 3'd4
    } estado_t;

    // A block is loadable only if it is non-empty and fits inside its reserved HD area.
    function automatic logic len_ok(input logic [LEN_W-1:0] len, input logic [LEN_W-1:0] max_len);
        return (len != {LEN_W{1'b0}}) && (len <= max_len);
    endfunction
endpackage

// File: rtl/carregador_programa_hd_tabela.sv
// Per-block length table: one synchronous write port, one asynchronous read port,
// cleared by the synchronous reset.
module tabela_tamanho_blocos
    import carregador_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int NUM_BLOCKS = NUM_BLOCKS_DEF,
    parameter int IDX_W      = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [ADDR_W-1:0] wr_len,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [ADDR_W-1:0] rd_len
);
    logic [ADDR_W-1:0] tab_q [NUM_BLOCKS];
    logic [ADDR_W-1:0] tab_d [NUM_BLOCKS];

    // Next table contents: the addressed entry takes the written length.
    always_comb begin
        for (int i = 0; i < NUM_BLOCKS; i++) begin
            if (wr_en && (int'(wr_idx) == i)) begin
                tab_d[i] = wr_len;
            end else begin
                tab_d[i] = tab_q[i];
            end
        end
    end

    // Read mux; indices beyond the table read as an empty block.
    always_comb begin
        rd_len = {ADDR_W{1'b0}};
        for (int i = 0; i < NUM_BLOCKS; i++) begin
            if (int'(rd_idx) == i) begin
                rd_len = tab_q[i];
            end else begin
                rd_len = rd_len;
            end
        end
    end

    // Table storage.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_BLOCKS; i++) begin
                tab_q[i] <= {ADDR_W{1'b0}};
            end
        end else begin
            tab_q <= tab_d;
        end
    end
endmodule

// File: rtl/carregador_programa_hd.sv
// Copies one HD block into instruction memory, one word per cycle, and reports
// completion or rejection/abort through one-cycle done/error pulses.
module carregador_programa_hd
    import carregador_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int BLOCK_SIZE = BLOCK_SIZE_DEF,
    parameter int NUM_BLOCKS = NUM_BLOCKS_DEF,
    parameter int IDX_W      = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [IDX_W-1:0]  block_num,
    input  logic [ADDR_W-1:0] dest_base,
    input  logic              abort,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic [ADDR_W-1:0] cfg_len,
    output logic              hd_rd_en,
    output logic [ADDR_W-1:0] hd_addr,
    input  logic [DATA_W-1:0] hd_data,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_data,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] words_loaded
);
    estado_t           state_q, state_d;
    logic [ADDR_W-1:0] hd_base_q, hd_base_d;
    logic [ADDR_W-1:0] dest_q, dest_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [ADDR_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [ADDR_W-1:0] words_q, words_d;
    logic              imem_we_q, imem_we_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [ADDR_W-1:0] tbl_len_s;
    logic              rd_issue_s;

    tabela_tamanho_blocos #(
        .ADDR_W    (ADDR_W),
        .NUM_BLOCKS(NUM_BLOCKS),
        .IDX_W     (IDX_W)
    ) u_tabela (
        .clk   (clk),
        .reset (reset),
        .wr_en (cfg_we),
        .wr_idx(cfg_idx),
        .wr_len(cfg_len),
        .rd_idx(block_num),
        .rd_len(tbl_len_s)
    );

    // abort must block the read in the very cycle it is raised, so the strobe is combinational.
    assign rd_issue_s   = (state_q == ST_STREAM) && !abort;
    assign hd_rd_en     = rd_issue_s;
    assign hd_addr      = rd_issue_s ? (hd_base_q + rd_cnt_q) : {ADDR_W{1'b0}};
    assign imem_we      = imem_we_q;
    assign imem_addr    = imem_addr_q;
    assign imem_data    = imem_we_q ? hd_data : {DATA_W{1'b0}};
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;
    assign words_loaded = words_q;

    // Next-state, counters, write pipeline and status pulses.
    always_comb begin
        state_d     = state_q;
        hd_base_d   = hd_base_q;
        dest_d      = dest_q;
        len_d       = len_q;
        rd_cnt_d    = rd_cnt_q;
        wr_cnt_d    = wr_cnt_q + (imem_we_q ? {{(ADDR_W-1){1'b0}}, 1'b1} : {ADDR_W{1'b0}});
        words_d     = words_q;
        done_d      = 1'b0;
        error_d     = 1'b0;
        // Each issued read turns into exactly one write on the following cycle.
        imem_we_d   = rd_issue_s;
        imem_addr_d = rd_issue_s ? (dest_q + rd_cnt_q) : {ADDR_W{1'b0}};

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    hd_base_d = ADDR_W'(block_num) * ADDR_W'(BLOCK_SIZE);
                    dest_d    = dest_base;
                    len_d     = tbl_len_s;
                    words_d   = {ADDR_W{1'b0}};
                    // Rejection is flagged so the error pulse lands in the CHECK cycle itself.
                    error_d   = !len_ok(LEN_W'(tbl_len_s), LEN_W'(BLOCK_SIZE));
                    state_d   = ST_CHECK;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_CHECK: begin
                rd_cnt_d = {ADDR_W{1'b0}};
                wr_cnt_d = {ADDR_W{1'b0}};
                if (!len_ok(LEN_W'(len_q), LEN_W'(BLOCK_SIZE))) begin
                    state_d = ST_IDLE;
                end else if (abort) begin
                    error_d = 1'b1;
                    words_d = {ADDR_W{1'b0}};
                    state_d = ST_FINISH;
                end else begin
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (abort) begin
                    error_d = 1'b1;
                    words_d = wr_cnt_d;
                    state_d = ST_FINISH;
                end else if (rd_cnt_q == (len_q - {{(ADDR_W-1){1'b0}}, 1'b1})) begin
                    state_d = ST_DRAIN;
                end else begin
                    rd_cnt_d = rd_cnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                end
            end
            ST_DRAIN: begin
                words_d = wr_cnt_d;
                state_d = ST_FINISH;
                if (abort) begin
                    error_d = 1'b1;
                end else begin
                    done_d  = 1'b1;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            hd_base_q   <= {ADDR_W{1'b0}};
            dest_q      <= {ADDR_W{1'b0}};
            len_q       <= {ADDR_W{1'b0}};
            rd_cnt_q    <= {ADDR_W{1'b0}};
            wr_cnt_q    <= {ADDR_W{1'b0}};
            imem_addr_q <= {ADDR_W{1'b0}};
            words_q     <= {ADDR_W{1'b0}};
            imem_we_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            hd_base_q   <= hd_base_d;
            dest_q      <= dest_d;
            len_q       <= len_d;
            rd_cnt_q    <= rd_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
            imem_addr_q <= imem_addr_d;
            words_q     <= words_d;
            imem_we_q   <= imem_we_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end
endmodule

// File: tb/tb_carregador_programa_hd.sv
// Self-checking bench for carregador_programa_hd: directed scenarios plus randomized loads
// against a cycle-level reference model of the load protocol.
module tb_carregador_programa_hd;
    localparam int BS = 200;

    logic        clk = 1'b0;
    logic        reset, start, abort, cfg_we;
    logic [2:0]  block_num, cfg_idx;
    logic [31:0] dest_base, cfg_len, hd_addr, hd_data, imem_addr, imem_data, words_loaded;
    logic        hd_rd_en, imem_we, busy, done, error;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int t0 = 0;
    int unsigned ref_tab [8];

    typedef struct { logic [31:0] a; logic [31:0] d; int c; } ev_t;
    ev_t rd_log[$];
    ev_t wr_log[$];
    int  done_log[$];
    int  err_log[$];
    int  busy_cnt = 0;
    logic log_en = 1'b0;

    // expected results produced by the model task
    int e_n, e_done, e_err, e_busy;
    logic [31:0] e_words;

    carregador_programa_hd dut (
        .clk(clk), .reset(reset), .start(start), .block_num(block_num), .dest_base(dest_base),
        .abort(abort), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_len(cfg_len),
        .hd_rd_en(hd_rd_en), .hd_addr(hd_addr), .hd_data(hd_data),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_data(imem_data),
        .busy(busy), .done(done), .error(error), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // HD model: word at address k holds 0x1000+k, valid the cycle after the strobe
    always @(posedge clk) begin
        if (hd_rd_en) hd_data <= 32'h0000_1000 + hd_addr;
        else          hd_data <= 32'hBAD0_BAD0;
    end

    always @(negedge clk) begin : monitor
        ev_t e;
        if (log_en) begin
            if (hd_rd_en) begin e.a = hd_addr; e.d = 32'h0; e.c = cyc; rd_log.push_back(e); end
            if (imem_we) begin e.a = imem_addr; e.d = imem_data; e.c = cyc; wr_log.push_back(e); end
            if (done) done_log.push_back(cyc);
            if (error) err_log.push_back(cyc);
            if (busy) busy_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic cfg_write(input int idx, input logic [31:0] len);
        cfg_we = 1'b1; cfg_idx = 3'(idx); cfg_len = len;
        tick();
        cfg_we = 1'b0;
        ref_tab[idx] = len;
    endtask

    task automatic launch(input logic [2:0] blk, input logic [31:0] dest, input logic cfg_same,
                          input logic [31:0] new_len, input logic abort_too);
        start = 1'b1; block_num = blk; dest_base = dest; abort = abort_too;
        cfg_we = cfg_same; cfg_idx = blk; cfg_len = new_len;
        rd_log.delete(); wr_log.delete(); done_log.delete(); err_log.delete();
        busy_cnt = 0; log_en = 1'b1;
        t0 = cyc;
        tick();
        start = 1'b0; abort = 1'b0; cfg_we = 1'b0;
        if (cfg_same) ref_tab[blk] = new_len;
    endtask

    // Reference model: what a load of length len with abort raised at t0+a (a<0: none) produces.
    task automatic model(input logic [31:0] len, input int a);
        if (len == 32'd0 || len > 32'(BS)) begin
            e_n = 0; e_done = -1; e_err = t0 + 1; e_busy = 1; e_words = 32'd0;
        end else if (a >= 1 && a <= int'(len) + 2) begin
            e_n = (a - 2 < 0) ? 0 : a - 2;
            e_done = -1; e_err = t0 + a + 1; e_busy = a + 1; e_words = 32'(e_n);
        end else begin
            e_n = int'(len); e_done = t0 + int'(len) + 3; e_err = -1;
            e_busy = int'(len) + 3; e_words = len;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; abort = 1'b0; cfg_we = 1'b0;
        block_num = 3'd0; cfg_idx = 3'd0; cfg_len = 32'd0; dest_base = 32'd0;
        tick(); tick();
        @(negedge clk);
        n_cmp++;
        if ({hd_rd_en, imem_we, busy, done, error} !== 5'b0) begin
            n_bad++; $display("FAIL reset_strobes got=%b exp=00000", {hd_rd_en, imem_we, busy, done, error});
        end
        n_cmp++;
        if ({hd_addr, imem_addr, imem_data, words_loaded} !== 128'd0) begin
            n_bad++; $display("FAIL reset_buses got=%h/%h/%h/%h exp=0", hd_addr, imem_addr, imem_data, words_loaded);
        end
        reset = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) ref_tab[i] = 0;
        // table starts cleared, so any block is rejected
        launch(3'd4, 32'h0, 1'b0, 32'h0, 1'b0);
        run(4);
        n_cmp++;
        if (err_log.size() != 1 || rd_log.size() != 0) begin
            n_bad++; $display("FAIL reset_table_cleared got errors=%0d reads=%0d exp=1/0", err_log.size(), rd_log.size());
        end
    endtask

    task automatic test_basic();
        cfg_write(2, 32'd5);
        launch(3'd2, 32'h40, 1'b0, 32'h0, 1'b0);
        run(10);
        n_cmp++;
        if (rd_log.size() != 5 || wr_log.size() != 5) begin
            n_bad++; $display("FAIL basic_counts got rd=%0d wr=%0d exp=5/5", rd_log.size(), wr_log.size());
        end
        for (int k = 0; k < 5 && k < rd_log.size(); k++) begin
            n_cmp++;
            if (rd_log[k].a !== 32'(400 + k) || rd_log[k].c != t0 + 2 + k) begin
                n_bad++; $display("FAIL basic_rd k=%0d got addr=%0d cyc=%0d exp addr=%0d cyc=%0d",
                                  k, rd_log[k].a, rd_log[k].c - t0, 400 + k, 2 + k);
            end
        end
        for (int k = 0; k < 5 && k < wr_log.size(); k++) begin
            n_cmp++;
            if (wr_log[k].a !== 32'(32'h40 + k) || wr_log[k].d !== 32'(32'h1190 + k) || wr_log[k].c != t0 + 3 + k) begin
                n_bad++; $display("FAIL basic_wr k=%0d got %h:%h@%0d exp %h:%h@%0d", k, wr_log[k].a, wr_log[k].d,
                                  wr_log[k].c - t0, 32'h40 + k, 32'h1190 + k, 3 + k);
            end
        end
        n_cmp++;
        if (done_log.size() != 1 || (done_log.size() == 1 && done_log[0] != t0 + 8) || err_log.size() != 0) begin
            n_bad++; $display("FAIL basic_done got dones=%0d errs=%0d exp one done at T+8", done_log.size(), err_log.size());
        end
        n_cmp++;
        if (busy_cnt != 8 || words_loaded !== 32'd5) begin
            n_bad++; $display("FAIL basic_busy_words got busy=%0d words=%0d exp=8/5", busy_cnt, words_loaded);
        end
    endtask

    task automatic test_invalid_len();
        logic [31:0] bad_len [2];
        bad_len[0] = 32'd0;
        bad_len[1] = 32'd201;
        for (int i = 0; i < 2; i++) begin
            cfg_write(3 - 2 * i, bad_len[i]);
            launch(3'(3 - 2 * i), 32'h80, 1'b0, 32'h0, 1'b0);
            run(5);
            n_cmp++;
            if (err_log.size() != 1 || (err_log.size() == 1 && err_log[0] != t0 + 1)) begin
                n_bad++; $display("FAIL invalid_err len=%0d got errs=%0d exp one error at T+1", bad_len[i], err_log.size());
            end
            n_cmp++;
            if (rd_log.size() != 0 || wr_log.size() != 0 || done_log.size() != 0 || busy_cnt != 1) begin
                n_bad++; $display("FAIL invalid_quiet len=%0d got rd=%0d wr=%0d done=%0d busy=%0d exp=0/0/0/1",
                                  bad_len[i], rd_log.size(), wr_log.size(), done_log.size(), busy_cnt);
            end
        end
    endtask

    task automatic test_abort();
        cfg_write(0, 32'd10);
        launch(3'd0, 32'h200, 1'b0, 32'h0, 1'b0);
        run(4);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        run(14);
        n_cmp++;
        if (rd_log.size() != 3 || wr_log.size() != 3) begin
            n_bad++; $display("FAIL abort_counts got rd=%0d wr=%0d exp=3/3", rd_log.size(), wr_log.size());
        end
        for (int k = 0; k < wr_log.size() && k < 3; k++) begin
            n_cmp++;
            if (wr_log[k].a !== 32'(32'h200 + k) || wr_log[k].d !== 32'(32'h1000 + k)) begin
                n_bad++; $display("FAIL abort_wr k=%0d got %h:%h exp %h:%h", k, wr_log[k].a, wr_log[k].d, 32'h200 + k, 32'h1000 + k);
            end
        end
        n_cmp++;
        if (err_log.size() != 1 || (err_log.size() == 1 && err_log[0] != t0 + 6) || done_log.size() != 0) begin
            n_bad++; $display("FAIL abort_err got errs=%0d dones=%0d exp one error at T+6, no done", err_log.size(), done_log.size());
        end
        n_cmp++;
        if (words_loaded !== 32'd3) begin
            n_bad++; $display("FAIL abort_words got=%0d exp=3", words_loaded);
        end
    endtask

    task automatic test_ignored_start_cfg();
        cfg_write(5, 32'd4);
        cfg_write(6, 32'd6);
        launch(3'd5, 32'h100, 1'b0, 32'h0, 1'b0);
        tick(); tick();
        start = 1'b1; block_num = 3'd6; dest_base = 32'h0;
        cfg_we = 1'b1; cfg_idx = 3'd5; cfg_len = 32'd9;
        tick();
        start = 1'b0; cfg_we = 1'b0; ref_tab[5] = 32'd9;
        run(14);
        n_cmp++;
        if (rd_log.size() != 4 || wr_log.size() != 4 || busy_cnt != 7) begin
            n_bad++; $display("FAIL midload_len got rd=%0d wr=%0d busy=%0d exp=4/4/7", rd_log.size(), wr_log.size(), busy_cnt);
        end
        n_cmp++;
        if (done_log.size() != 1 || (done_log.size() == 1 && done_log[0] != t0 + 7) || err_log.size() != 0) begin
            n_bad++; $display("FAIL midload_done got dones=%0d errs=%0d exp one done at T+7", done_log.size(), err_log.size());
        end
        n_cmp++;
        if (words_loaded !== 32'd4) begin
            n_bad++; $display("FAIL midload_words got=%0d exp=4", words_loaded);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_a [3];
        exp_a[0] = 32'hFFFF_FFFE; exp_a[1] = 32'hFFFF_FFFF; exp_a[2] = 32'h0000_0000;
        cfg_write(7, 32'd3);
        launch(3'd7, 32'hFFFF_FFFE, 1'b0, 32'h0, 1'b0);
        run(8);
        n_cmp++;
        if (wr_log.size() != 3 || done_log.size() != 1) begin
            n_bad++; $display("FAIL wrap_counts got wr=%0d done=%0d exp=3/1", wr_log.size(), done_log.size());
        end
        for (int k = 0; k < wr_log.size() && k < 3; k++) begin
            n_cmp++;
            if (wr_log[k].a !== exp_a[k] || wr_log[k].d !== 32'(32'h1578 + k)) begin
                n_bad++; $display("FAIL wrap_wr k=%0d got %h:%h exp %h:%h", k, wr_log[k].a, wr_log[k].d, exp_a[k], 32'h1578 + k);
            end
        end
    endtask

    task automatic test_random();
        logic [2:0]  blk;
        logic [31:0] dest, len, nl;
        logic        cfg_same, ab0;
        int          sel, a, lim;
        for (int it = 0; it < 24; it++) begin
            blk = 3'($urandom_range(0, 7));
            sel = $urandom_range(0, 9);
            case (sel)
                0: len = 32'd0;
                1: len = 32'd1;
                2: len = 32'd200;
                3: len = 32'd201;
                4: len = $urandom;
                default: len = 32'($urandom_range(2, 12));
            endcase
            cfg_write(int'(blk), len);
            dest     = $urandom;
            cfg_same = ($urandom_range(0, 3) == 0);
            nl       = 32'($urandom_range(1, 20));
            ab0      = ($urandom_range(0, 5) == 0);
            lim      = (len >= 32'd1 && len <= 32'(BS)) ? int'(len) + 6 : 4;
            a        = ($urandom_range(0, 2) == 0) ? $urandom_range(1, lim - 2) : -1;
            launch(blk, dest, cfg_same, nl, ab0);
            model(len, a);
            for (int c = 1; c <= lim; c++) begin
                abort = (c == a);
                tick();
            end
            abort = 1'b0;
            n_cmp++;
            if (rd_log.size() != e_n || wr_log.size() != e_n) begin
                n_bad++; $display("FAIL rnd_counts it=%0d got rd=%0d wr=%0d exp=%0d", it, rd_log.size(), wr_log.size(), e_n);
            end
            for (int k = 0; k < e_n && k < rd_log.size(); k++) begin
                n_cmp++;
                if (rd_log[k].a !== 32'(int'(blk) * BS + k) || rd_log[k].c != t0 + 2 + k) begin
                    n_bad++; $display("FAIL rnd_rd it=%0d k=%0d got %0d@%0d exp %0d@%0d", it, k, rd_log[k].a,
                                      rd_log[k].c - t0, int'(blk) * BS + k, 2 + k);
                end
            end
            for (int k = 0; k < e_n && k < wr_log.size(); k++) begin
                n_cmp++;
                if (wr_log[k].a !== 32'(dest + 32'(k)) || wr_log[k].d !== 32'(32'h1000 + int'(blk) * BS + k)
                    || wr_log[k].c != t0 + 3 + k) begin
                    n_bad++; $display("FAIL rnd_wr it=%0d k=%0d got %h:%h@%0d exp %h:%h@%0d", it, k, wr_log[k].a,
                                      wr_log[k].d, wr_log[k].c - t0, dest + 32'(k), 32'h1000 + int'(blk) * BS + k, 3 + k);
                end
            end
            n_cmp++;
            if ((e_done < 0 && done_log.size() != 0) || (e_done >= 0 && (done_log.size() != 1 || done_log[0] != e_done))) begin
                n_bad++; $display("FAIL rnd_done it=%0d got n=%0d exp cyc=%0d", it, done_log.size(), e_done - t0);
            end
            n_cmp++;
            if ((e_err < 0 && err_log.size() != 0) || (e_err >= 0 && (err_log.size() != 1 || err_log[0] != e_err))) begin
                n_bad++; $display("FAIL rnd_err it=%0d got n=%0d exp cyc=%0d", it, err_log.size(), e_err - t0);
            end
            n_cmp++;
            if (busy_cnt != e_busy || words_loaded !== e_words) begin
                n_bad++; $display("FAIL rnd_busy_words it=%0d got busy=%0d words=%0d exp=%0d/%0d",
                                  it, busy_cnt, words_loaded, e_busy, e_words);
            end
        end
    endtask

    task automatic test_reset_midload();
        cfg_write(2, 32'd5);
        launch(3'd2, 32'h0, 1'b0, 32'h0, 1'b0);
        run(3);
        reset = 1'b1;
        tick();
        @(negedge clk);
        n_cmp++;
        if ({hd_rd_en, imem_we, busy, done, error} !== 5'b0 || words_loaded !== 32'd0) begin
            n_bad++; $display("FAIL midreset_outputs got=%b words=%0d exp=00000/0",
                              {hd_rd_en, imem_we, busy, done, error}, words_loaded);
        end
        reset = 1'b0;
        for (int i = 0; i < 8; i++) ref_tab[i] = 0;
        run(6);
        n_cmp++;
        if (rd_log.size() != 3 || wr_log.size() != 2 || done_log.size() != 0 || err_log.size() != 0) begin
            n_bad++; $display("FAIL midreset_activity got rd=%0d wr=%0d done=%0d err=%0d exp=3/2/0/0",
                              rd_log.size(), wr_log.size(), done_log.size(), err_log.size());
        end
        cfg_write(2, 32'd5);
        launch(3'd2, 32'h40, 1'b0, 32'h0, 1'b0);
        run(10);
        n_cmp++;
        if (done_log.size() != 1 || (done_log.size() == 1 && done_log[0] != t0 + 8) || words_loaded !== 32'd5
            || wr_log.size() != 5) begin
            n_bad++; $display("FAIL midreset_reload got dones=%0d words=%0d wr=%0d exp one done at T+8, 5, 5",
                              done_log.size(), words_loaded, wr_log.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_invalid_len();
        test_abort();
        test_ignored_start_cfg();
        test_wrap();
        test_random();
        test_reset_midload();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
